stack_pointer_adder: RTL and testbench

- Stack-pointer post-adjust unit in the CPU datapath, placed between the stack-pointer register read port and its write-back mux.
- On a return (pop of the return address), it increments the incoming stack pointer by STEP. Otherwise it forwards the pointer unchanged.
- The result is registered, giving one clock of latency, so its output can feed the SP register write-back on the following cycle.

---
 rtl/stack_pointer_adder.sv | 67 ++++++
 tb/tb_stack_pointer_adder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/stack_pointer_adder.sv
// -----------------------------------------------------------------------------
// stack_pointer_adder
//
// Stack-pointer post-adjust unit. It sits between the SP register read port and
// the SP write-back mux. On a return it adds STEP to the incoming pointer.
// Otherwise it forwards the pointer unchanged. The result is registered, so
// there is exactly one clock of latency and no combinational input-to-output
// path.
//
// Parameters
//   W    : stack-pointer width in bits (2..64)
//   STEP : unsigned increment applied on a return (must be < 2^W)
//
// Ports
//   clk          : system clock, rising-edge active
//   rst          : synchronous active-high reset, priority over all inputs
//   input_stack  : current stack-pointer value
//   ret_enable   : 1 = return in progress (add STEP), 0 = pass through
//   output_stack : registered adjusted stack pointer
//   sp_wrap      : registered carry-out of the last addition (0 on pass-through)
// -----------------------------------------------------------------------------
module stack_pointer_adder #(
    parameter int                W    = 16,
    parameter longint unsigned   STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] input_stack,
    input  logic         ret_enable,
    output logic [W-1:0] output_stack,
    output logic         sp_wrap
);

    // STEP zero-extended to the W+1 bit adder width.
    localparam logic [W:0] STEP_EXT = (W+1)'(STEP);

    logic [W:0]   sum_next;
    logic [W-1:0] output_stack_reg;
    logic [W-1:0] output_stack_next;
    logic         sp_wrap_reg;
    logic         sp_wrap_next;

    // Unsigned W+1 bit sum: low W bits are the new pointer, bit W is the carry.
    always_comb begin
        sum_next          = {1'b0, input_stack} + STEP_EXT;
        output_stack_next = input_stack;
        sp_wrap_next      = 1'b0;
        if (ret_enable) begin
            output_stack_next = sum_next[W-1:0];
            sp_wrap_next      = sum_next[W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            output_stack_reg <= '0;
            sp_wrap_reg      <= 1'b0;
        end else begin
            output_stack_reg <= output_stack_next;
            sp_wrap_reg      <= sp_wrap_next;
        end
    end

    assign output_stack = output_stack_reg;
    assign sp_wrap      = sp_wrap_reg;

endmodule

// File: tb/tb_stack_pointer_adder.sv
// -----------------------------------------------------------------------------
// tb_stack_pointer_adder
//
// Self-checking bench for stack_pointer_adder. Two instances run side by side:
// the default W=16/STEP=1 build and a W=8/STEP=2 variant. Each cycle the
// stimulus is driven on the falling edge, the expected result is pushed to a
// scoreboard queue, and it is popped and compared 1 time unit after the next
// rising edge. The same values are compared again on the following falling
// edge to confirm the output holds for the whole cycle.
// -----------------------------------------------------------------------------
module tb_stack_pointer_adder;

    typedef struct packed {
        logic [15:0] sp16;
        logic        wrap16;
        logic [7:0]  sp8;
        logic        wrap8;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ret_enable;
    logic [15:0] in16;
    logic [7:0]  in8;
    logic [15:0] out16;
    logic        wrap16;
    logic [7:0]  out8;
    logic        wrap8;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    exp_t exp_q[$];

    stack_pointer_adder #(.W(16), .STEP(1)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .input_stack  (in16),
        .ret_enable   (ret_enable),
        .output_stack (out16),
        .sp_wrap      (wrap16)
    );

    stack_pointer_adder #(.W(8), .STEP(2)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .input_stack  (in8),
        .ret_enable   (ret_enable),
        .output_stack (out8),
        .sp_wrap      (wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: unsigned W+1 bit add, reset forces zero.
    function automatic exp_t model(input logic r, input logic ret,
                                   input logic [15:0] a16, input logic [7:0] a8);
        exp_t e;
        logic [16:0] s16;
        logic [8:0]  s8;
        s16 = {1'b0, a16} + 17'd1;
        s8  = {1'b0, a8} + 9'd2;
        if (r) begin
            e = '0;
        end else if (ret) begin
            e.sp16 = s16[15:0]; e.wrap16 = s16[16];
            e.sp8  = s8[7:0];   e.wrap8  = s8[8];
        end else begin
            e.sp16 = a16; e.wrap16 = 1'b0;
            e.sp8  = a8;  e.wrap8  = 1'b0;
        end
        return e;
    endfunction

    // One transaction: drive, push expected, compare after edge and mid-cycle.
    task automatic cycle(input logic r, input logic ret,
                         input logic [15:0] a16, input logic [7:0] a8);
        exp_t e;
        rst        = r;
        ret_enable = ret;
        in16       = a16;
        in8        = a8;
        exp_q.push_back(model(r, ret, a16, a8));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_value("queue_empty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        $display("txn %0d rst=%0b ret=%0b in16=%h in8=%h -> out16=%h wrap16=%0b out8=%h wrap8=%0b",
                 txn, r, ret, a16, a8, out16, wrap16, out8, wrap8);
        check_value("out16",  32'(out16),  32'(e.sp16));
        check_value("wrap16", 32'(wrap16), 32'(e.wrap16));
        check_value("out8",   32'(out8),   32'(e.sp8));
        check_value("wrap8",  32'(wrap8),  32'(e.wrap8));
        @(negedge clk);
        check_value("hold_out16",  32'(out16),  32'(e.sp16));
        check_value("hold_wrap16", 32'(wrap16), 32'(e.wrap16));
        check_value("hold_out8",   32'(out8),   32'(e.sp8));
        txn++;
    endtask

    initial begin
        rst = 1'b1; ret_enable = 1'b0; in16 = '0; in8 = '0;
        // Reset, then pass-through.
        cycle(1'b1, 1'b0, 16'h0000, 8'h00);
        cycle(1'b1, 1'b0, 16'h0000, 8'h00);
        cycle(1'b0, 1'b0, 16'h0000, 8'h00);
        cycle(1'b0, 1'b0, 16'h1015, 8'h33);
        // Return increment; W=8 variant wraps at FE.
        cycle(1'b0, 1'b1, 16'hABA2, 8'hFE);
        // Wrap boundary, then clearing of the flag.
        cycle(1'b0, 1'b1, 16'hFFFF, 8'h10);
        cycle(1'b0, 1'b0, 16'h0042, 8'hFF);
        // Latency: toggle ret_enable with a constant pointer.
        cycle(1'b0, 1'b1, 16'h7FFF, 8'hFF);
        cycle(1'b0, 1'b0, 16'h7FFF, 8'hFD);
        cycle(1'b0, 1'b1, 16'h7FFF, 8'hFD);
        cycle(1'b0, 1'b0, 16'h7FFF, 8'h7F);
        // Constant inputs must not accumulate.
        cycle(1'b0, 1'b1, 16'h0100, 8'h20);
        cycle(1'b0, 1'b1, 16'h0100, 8'h20);
        // Reset priority mid-operation, then release.
        cycle(1'b1, 1'b1, 16'h1234, 8'h80);
        cycle(1'b0, 1'b1, 16'h1234, 8'h80);
        // Random traffic with occasional reset.
        for (int i = 0; i < 40; i++) begin
            cycle(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  16'($urandom), 8'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
